// File: rtl/pm_loader_pkg.sv
// Shared types and constants for the program-memory loader.
// Holds the FSM encoding, header geometry and word sizing helper.
package pm_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam int unsigned HDR_BYTES      = 4;
  localparam int unsigned HDR_ADDR_BYTES = 2;
  localparam int unsigned CNT_W          = 16;

  function automatic int unsigned bytes_per_word(input int unsigned pmd_size);
    return pmd_size / 8;
  endfunction

endpackage

// File: rtl/pm_word_assembler.sv
// Byte-to-word shift register: bytes enter at the LSB so the first byte
// of a word ends up in the MSB position.
module pm_word_assembler
  import pm_loader_pkg::*;
#(
  parameter int unsigned PMD_SIZE = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                shift_en,
  input  logic [7:0]          byte_in,
  output logic [PMD_SIZE-1:0] word_c,
  output logic                word_full_c
);

  localparam int unsigned BPW   = bytes_per_word(PMD_SIZE);
  localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [PMD_SIZE-1:0] word;
  logic [IDX_W-1:0]    idx;

  // Word as it will look once the current byte is shifted in.
  assign word_c      = PMD_SIZE'({word, byte_in});
  assign word_full_c = shift_en && (idx == IDX_W'(BPW - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word <= '0;
      idx  <= '0;
    end else if (clear) begin
      word <= '0;
      idx  <= '0;
    end else if (shift_en) begin
      word <= word_c;
      idx  <= word_full_c ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/pm_loader.sv
// Program-memory loader: parses an address/count header from a byte stream,
// assembles words MSB-first and strobes one memory write per word.
module pm_loader
  import pm_loader_pkg::*;
#(
  parameter int unsigned PMA_SIZE = 16,
  parameter int unsigned PMD_SIZE = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_start,
  input  logic                ld_valid,
  input  logic [7:0]          ld_data,
  output logic                ld_ready,
  output logic                ld_pm_cslt,
  output logic                ld_pm_wrb,
  output logic [PMA_SIZE-1:0] ld_pm_add,
  output logic [PMD_SIZE-1:0] ld_pm_dt,
  output logic                ld_ps_hold,
  output logic                ld_done
);

  localparam int unsigned HDR_IDX_W = $clog2(HDR_BYTES);

  state_t               state;
  logic [HDR_IDX_W-1:0] hdr_idx;
  logic [PMA_SIZE-1:0]  addr;
  logic [CNT_W-1:0]     count;

  logic                 accept_c;
  logic                 shift_en_c;
  logic                 clear_c;
  logic                 word_full_c;
  logic [PMD_SIZE-1:0]  word_c;
  logic [CNT_W-1:0]     count_shift_c;

  // ld_ready is only ever high in HDR/DATA, so it alone qualifies a byte.
  assign accept_c      = ld_valid && ld_ready;
  assign shift_en_c    = accept_c && (state == ST_DATA);
  assign clear_c       = (state == ST_IDLE) && ld_start;
  assign count_shift_c = {count[7:0], ld_data};

  pm_word_assembler #(
    .PMD_SIZE (PMD_SIZE)
  ) u_asm (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear_c),
    .shift_en    (shift_en_c),
    .byte_in     (ld_data),
    .word_c      (word_c),
    .word_full_c (word_full_c)
  );

  // Session FSM; every output is a flop loaded alongside the state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      hdr_idx    <= '0;
      addr       <= '0;
      count      <= '0;
      ld_ready   <= 1'b0;
      ld_pm_cslt <= 1'b0;
      ld_pm_wrb  <= 1'b0;
      ld_pm_add  <= '0;
      ld_pm_dt   <= '0;
      ld_ps_hold <= 1'b0;
      ld_done    <= 1'b0;
    end else begin
      ld_pm_cslt <= 1'b0;
      ld_pm_wrb  <= 1'b0;
      ld_done    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (ld_start) begin
            state      <= ST_HDR;
            hdr_idx    <= '0;
            ld_ready   <= 1'b1;
            ld_ps_hold <= 1'b1;
          end
        end

        ST_HDR: begin
          if (accept_c) begin
            // Address bytes shift through a PMA_SIZE register; upper header bits fall off.
            if (hdr_idx < HDR_IDX_W'(HDR_ADDR_BYTES)) begin
              addr <= PMA_SIZE'({addr, ld_data});
            end else begin
              count <= count_shift_c;
            end
            hdr_idx <= hdr_idx + HDR_IDX_W'(1);
            if (hdr_idx == HDR_IDX_W'(HDR_BYTES - 1)) begin
              if (count_shift_c == '0) begin
                state      <= ST_DONE;
                ld_ready   <= 1'b0;
                ld_ps_hold <= 1'b0;
                ld_done    <= 1'b1;
              end else begin
                state <= ST_DATA;
              end
            end
          end
        end

        ST_DATA: begin
          if (word_full_c) begin
            state      <= ST_WRITE;
            ld_ready   <= 1'b0;
            ld_pm_cslt <= 1'b1;
            ld_pm_wrb  <= 1'b1;
            ld_pm_add  <= addr;
            ld_pm_dt   <= word_c;
          end
        end

        ST_WRITE: begin
          addr  <= addr + PMA_SIZE'(1);
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state      <= ST_DONE;
            ld_ps_hold <= 1'b0;
            ld_done    <= 1'b1;
          end else begin
            state    <= ST_DATA;
            ld_ready <= 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state      <= ST_IDLE;
          ld_ready   <= 1'b0;
          ld_ps_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pm_loader.sv
// Scoreboard bench for pm_loader: the driver predicts writes/done pulses from
// the header and byte stream, and a monitor pops and checks them as they appear.
module tb_pm_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_ready;
  logic        ld_pm_cslt;
  logic        ld_pm_wrb;
  logic [15:0] ld_pm_add;
  logic [31:0] ld_pm_dt;
  logic        ld_ps_hold;
  logic        ld_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t        wr_q[$];
  int         done_q[$];
  logic [7:0] stim[$];

  pm_loader #(
    .PMA_SIZE (16),
    .PMD_SIZE (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_pm_cslt (ld_pm_cslt),
    .ld_pm_wrb  (ld_pm_wrb),
    .ld_pm_add  (ld_pm_add),
    .ld_pm_dt   (ld_pm_dt),
    .ld_ps_hold (ld_ps_hold),
    .ld_done    (ld_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick_gap(input int gap);
    return (gap < 0) ? int'($urandom_range(3, 0)) : gap;
  endfunction

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  // kind: 0 plain byte, 1 completes a word, 2 completes the final word, 3 last header byte of an empty load.
  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int kind, input logic [15:0] wa, input logic [31:0] wd);
    int  n;
    int  acc;
    wr_t e;
    n = 0;
    ld_valid = 1'b1;
    ld_data  = b;
    while (!ld_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ld_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: ld_ready stayed 0 for %0d cycles, required 1", n);
      ld_valid = 1'b0;
      return;
    end
    chk("byte_hold", 64'(ld_ps_hold), 64'd1);
    acc = cyc + 1;
    if (kind == 1 || kind == 2) begin
      e.addr = wa;
      e.data = wd;
      e.cyc  = acc;
      wr_q.push_back(e);
    end
    if (kind == 2) done_q.push_back(acc + 1);
    if (kind == 3) done_q.push_back(acc);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic run_session(input logic [15:0] a, input logic [15:0] n, input int gap,
                             input bit glitch, input bit junk_idle);
    logic [15:0] ea[$];
    logic [31:0] ew[$];
    logic [7:0]  hdr[4];
    int          t;
    int          kind;
    // Reference: word i lands at a+i (mod 2^16), built from bytes 4i..4i+3 MSB first.
    for (int i = 0; i < int'(n); i++) begin
      ea.push_back(a + 16'(i));
      ew.push_back(32'(stim[4*i]) * 32'h0100_0000 + 32'(stim[4*i+1]) * 32'h0001_0000 +
                   32'(stim[4*i+2]) * 32'h0000_0100 + 32'(stim[4*i+3]));
    end
    chk("idle_ready", 64'(ld_ready), 64'd0);
    chk("idle_hold", 64'(ld_ps_hold), 64'd0);
    if (junk_idle) begin
      ld_valid = 1'b1;
      ld_data  = 8'hA5;
      repeat (3) begin
        @(negedge clk);
        chk("idle_ready_junk", 64'(ld_ready), 64'd0);
      end
      ld_valid = 1'b0;
    end
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    chk("start_hold", 64'(ld_ps_hold), 64'd1);
    chk("start_ready", 64'(ld_ready), 64'd1);
    hdr[0] = a[15:8];
    hdr[1] = a[7:0];
    hdr[2] = n[15:8];
    hdr[3] = n[7:0];
    for (int k = 0; k < 4; k++) begin
      send_byte(hdr[k], (k == 3 && n == 16'd0) ? 3 : 0, 16'd0, 32'd0);
      repeat (pick_gap(gap)) @(negedge clk);
    end
    for (int i = 0; i < int'(n); i++) begin
      for (int k = 0; k < 4; k++) begin
        kind = (k != 3) ? 0 : ((i == int'(n) - 1) ? 2 : 1);
        send_byte(stim[4*i+k], kind, ea[i], ew[i]);
        if (glitch && i == 0 && k == 0) begin
          ld_start = 1'b1;
          @(negedge clk);
          ld_start = 1'b0;
        end
        repeat (pick_gap(gap)) @(negedge clk);
      end
    end
    t = 0;
    while ((wr_q.size() != 0 || done_q.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("session_drain", 64'(wr_q.size() + done_q.size()), 64'd0);
    wr_q.delete();
    done_q.delete();
    @(negedge clk);
    chk("post_ready", 64'(ld_ready), 64'd0);
    chk("post_hold", 64'(ld_ps_hold), 64'd0);
  endtask

  // Monitor: samples just after each rising edge and checks against the scoreboard.
  initial begin : monitor
    wr_t         e;
    int          dc;
    logic [15:0] last_add;
    logic [31:0] last_dt;
    last_add = '0;
    last_dt  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        last_add = '0;
        last_dt  = '0;
        chk("reset_outputs", 64'({ld_ready, ld_pm_cslt, ld_pm_wrb, ld_ps_hold, ld_done, ld_pm_add, ld_pm_dt}), 64'd0);
      end else begin
        if (ld_pm_cslt) begin
          if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: strobe at %0h data %0h, required no strobe", ld_pm_add, ld_pm_dt);
          end else begin
            e = wr_q.pop_front();
            chk("wr_addr", 64'(ld_pm_add), 64'(e.addr));
            chk("wr_data", 64'(ld_pm_dt), 64'(e.data));
            chk("wr_cycle", 64'(cyc), 64'(e.cyc));
            last_add = e.addr;
            last_dt  = e.data;
          end
          chk("wr_wrb", 64'(ld_pm_wrb), 64'd1);
          chk("wr_ready", 64'(ld_ready), 64'd0);
          chk("wr_hold", 64'(ld_ps_hold), 64'd1);
        end else begin
          chk("idle_wrb", 64'(ld_pm_wrb), 64'd0);
          chk("keep_add", 64'(ld_pm_add), 64'(last_add));
          chk("keep_dt", 64'(ld_pm_dt), 64'(last_dt));
        end
        if (ld_done) begin
          if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: ld_done=1 at cycle %0d, required 0", cyc);
          end else begin
            dc = done_q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(dc));
          end
          chk("done_hold", 64'(ld_ps_hold), 64'd0);
          chk("done_ready", 64'(ld_ready), 64'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin : driver
    logic [15:0] ra;
    logic [15:0] rn;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({ld_ready, ld_pm_cslt, ld_pm_wrb, ld_ps_hold, ld_done, ld_pm_add, ld_pm_dt}), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Two words at full rate, with ld_valid wiggled while idle.
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_session(16'h0010, 16'd2, 0, 1'b0, 1'b1);

    // Empty load.
    stim.delete();
    run_session(16'h1234, 16'd0, 0, 1'b0, 1'b0);

    // Address wrap.
    fill_random(8);
    run_session(16'hFFFF, 16'd2, 0, 1'b0, 1'b0);

    // Stalled stream with a stray ld_start during DATA.
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_session(16'h0010, 16'd2, 3, 1'b1, 1'b0);

    for (int s = 0; s < 6; s++) begin
      ra = 16'($urandom);
      if (s == 0) ra = 16'hFFFE;
      rn = 16'($urandom_range(4, 0));
      fill_random(4 * int'(rn));
      run_session(ra, rn, -1, 1'b1, s[0]);
    end

    // Abort mid-word, then reload.
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    send_byte(8'h00, 0, 16'd0, 32'd0);
    send_byte(8'h10, 0, 16'd0, 32'd0);
    send_byte(8'h00, 0, 16'd0, 32'd0);
    send_byte(8'h02, 0, 16'd0, 32'd0);
    send_byte(stim[0], 0, 16'd0, 32'd0);
    send_byte(stim[1], 0, 16'd0, 32'd0);
    wr_q.delete();
    done_q.delete();
    reset = 1'b0;
    #1;
    chk("abort_outputs", 64'({ld_ready, ld_pm_cslt, ld_pm_wrb, ld_ps_hold, ld_done, ld_pm_add, ld_pm_dt}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_session(16'h0010, 16'd2, 0, 1'b0, 1'b0);

    chk("leftover_expectations", 64'(wr_q.size() + done_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pm_loader.md
# pm_loader

Program-memory loader that fills program memory before the program sequencer runs. It accepts a byte stream over a valid/ready handshake and parses a 4-byte header (start address, word count). It assembles PMD_SIZE-bit instruction words MSB-first and issues one program-memory write strobe per word. The sequencer is held in reset for the duration of a load. It is the write-side counterpart of the sequencer's instruction fetch and feeds the memory block's program-data input port.

## Interface
- PMA_SIZE, 16, program-memory address width (≤16)
- PMD_SIZE, 32, program-memory data width; multiple of 8
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- ld_start  in  1  one-cycle pulse, begins a load session from IDLE
- ld_valid  in  1  byte on ld_data is valid
- ld_data  in  8  stream byte
- ld_ready  out  1  loader accepts a byte this cycle
- ld_pm_cslt  out  1  program-memory chip select for the write
- ld_pm_wrb  out  1  1 = write (asserted together with ld_pm_cslt)
- ld_pm_add  out  PMA_SIZE  write address
- ld_pm_dt  out  PMD_SIZE  write data
- ld_ps_hold  out  1  holds the sequencer in reset while loading
- ld_done  out  1  one-cycle pulse, session complete

## Operation
- Byte accepted at a rising edge when ld_valid && ld_ready; otherwise ld_data is ignored.
- States:
  - IDLE: ready=0, hold=0. ld_start → HDR, byte index cleared, hold=1 from the next cycle.
  - HDR: ready=1. Takes 4 bytes: addr[15:8], addr[7:0], count[15:8], count[7:0]. The address register keeps addr[PMA_SIZE-1:0]. After the 4th byte: count==0 → DONE, else → DATA.
  - DATA: ready=1. Shifts bytes MSB-first into the word register. After byte PMD_SIZE/8 → WRITE.
  - WRITE: ready=0. cslt=1, wrb=1, add=current address, dt=assembled word, all for exactly one cycle. Then address +1 (wraps mod 2^PMA_SIZE) and count −1. If the remaining count is 0 → DONE, else → DATA.
  - DONE: ready=0, hold=0, ld_done=1 for one cycle. Then → IDLE.
- ld_start outside IDLE is ignored. ld_valid outside HDR/DATA is ignored.
- The stream may stall at any point (valid low); there is no timeout.
- Count 0xFFFF is legal, giving 65535 writes. An address wrap from 2^PMA_SIZE−1 to 0 is legal.

## Timing
- Reset values: ld_ready=0, ld_pm_cslt=0, ld_pm_wrb=0, ld_pm_add=0, ld_pm_dt=0, ld_ps_hold=0, ld_done=0; state IDLE.
- All outputs are registered and there is no combinational path from inputs to outputs.
- ld_ps_hold=1 from the cycle after ld_start through the last WRITE cycle inclusive.
- The WRITE strobe occurs in the cycle after the last byte of a word is accepted. Each word costs PMD_SIZE/8 + 1 cycles minimum (one bubble).
- ld_done occurs in the cycle after the final WRITE, or after the 4th header byte when count==0.
- Outside WRITE, ld_pm_cslt and ld_pm_wrb are 0, and ld_pm_add/ld_pm_dt hold their last values.
- Reset asserted mid-session aborts the load immediately: all outputs go to reset values and no partial word is written.

## Structure
- Package pm_loader_pkg holds:
  - the state encoding (IDLE, HDR, DATA, WRITE, DONE);
  - HDR_BYTES=4;
  - the function BYTES_PER_WORD(PMD_SIZE).
- One sub-module, pm_word_assembler: byte shift register plus byte index, with a word_full flag and a clear input.
- The top module holds the FSM, the address and count registers, and the output registers.

## Test plan
- Header 00 10 00 02, then bytes 11 22 33 44 55 66 77 88 at full rate → writes 0x11223344 @0x0010 and 0x55667788 @0x0011. ld_done fires one cycle after the second WRITE. hold is high throughout and low in the DONE cycle.
- Header 12 34 00 00 → no write strobe, ld_done one cycle after the 4th byte, hold high only for the HDR cycles.
- Header FF FF 00 02 with two words → writes go to 0xFFFF then 0x0000.
- Random ld_valid gaps (e.g., 3 idle cycles between every byte) on the first scenario → identical writes and data, with the strobe one cycle after the last byte of each word.
- ld_start pulsed again during DATA, and ld_valid driven during IDLE and WRITE → ignored; ld_ready is 0 in IDLE, WRITE and DONE.
- Reset asserted after 2 data bytes of the first word → outputs return to reset values in the same cycle, with no strobe. A subsequent full session then loads correctly.
